// File: rtl/cmp_arb_pkg.sv
// ============================================================================
// Module      : cmp_arb_pkg
// Description : Shared types and helpers for the comparator-sharing arbiter.
//               Holds the FSM state encoding and the requester-ID width
//               function used to size ID buses from NREQ.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_arb_pkg;

  // Two-bit state encoding; values are fixed so waveforms stay readable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } cmp_arb_state_e;

  // Bits needed to index n requesters (never less than 1).
  function automatic int cmp_arb_id_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_mag_core.sv
// ============================================================================
// Module      : cmp_mag_core
// Description : Combinational unsigned magnitude comparator. Exactly one of
//               eq/lt/gt is high for any operand pair.
// Ports       : a, b      - WIDTH-bit unsigned operands
//               eq        - a == b
//               lt        - a <  b
//               gt        - a >  b
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_mag_core #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a <  b);
  assign gt = (a >  b);

endmodule

`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
// ============================================================================
// Module      : cmp_share_arbiter
// Description : Shares one magnitude comparator among NREQ requesters. A
//               round-robin arbiter picks one operand pair in IDLE, the pair is
//               compared in CMP, and the registered result is offered with the
//               requester ID in RESP until the consumer accepts it.
//               Optional macro CMP_ARB_FIXED_PRIO_EN: fixed priority (lowest
//               index wins), no round-robin pointer.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_valid/req_ready   - per-requester handshake (ready one-hot)
//               req_a, req_b          - packed operands, slot i at [i*WIDTH +: WIDTH]
//               rsp_valid/rsp_ready   - response handshake
//               rsp_id                - owner of the current result
//               rsp_eq/rsp_lt/rsp_gt  - registered compare result
//               busy                  - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_share_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*WIDTH-1:0]               req_a,
  input  logic [NREQ*WIDTH-1:0]               req_b,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [cmp_arb_id_width(NREQ)-1:0]   rsp_id,
  output logic                                rsp_eq,
  output logic                                rsp_lt,
  output logic                                rsp_gt,
  output logic                                busy
);

  localparam int IDW = cmp_arb_id_width(NREQ);

  cmp_arb_state_e   r_state;
  cmp_arb_state_e   w_state_nxt;

  logic [IDW-1:0]   w_base;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_grant;
  logic             w_found;
  logic             w_accept;

  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_gt;

  // --------------------------------------------------------------------------
  // Arbitration base: the scan starts at the round-robin pointer, or at 0 when
  // fixed priority is selected.
  // --------------------------------------------------------------------------
`ifdef CMP_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_rr_ptr;

  // Pointer only moves on an actual accept, so a requester that withdraws
  // before being granted leaves the rotation untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (int'(w_grant) == NREQ - 1) ? '0 : w_grant + 1'b1;
    end
  end

  assign w_base = r_rr_ptr;
`endif

  // First valid requester scanning base, base+1, ... modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(w_base) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_found;

  // Ready is gated by rst_n so no accept is advertised while reset is held,
  // even though the FSM already sits in IDLE.
  always_comb begin
    req_ready = '0;
    if (w_accept && rst_n) req_ready[w_grant] = 1'b1;
  end

  assign w_sel_a = req_a[w_grant*WIDTH +: WIDTH];
  assign w_sel_b = req_b[w_grant*WIDTH +: WIDTH];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)   w_state_nxt = CMP;
      CMP:                    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Comparator sees only the latched operands, so requester inputs are never
  // sampled outside the accept cycle.
  cmp_mag_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (r_a),
    .b  (r_b),
    .eq (w_eq),
    .lt (w_lt),
    .gt (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        r_id <= w_grant;
      end
      // Results change only here, so they hold through RESP and after it.
      if (r_state == CMP) begin
        r_eq <= w_eq;
        r_lt <= w_lt;
        r_gt <= w_gt;
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_id;
  assign rsp_eq    = r_eq;
  assign rsp_lt    = r_lt;
  assign rsp_gt    = r_gt;

endmodule

`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
// ============================================================================
// Module      : tb_cmp_share_arbiter
// Description : Directed self-checking bench for cmp_share_arbiter
//               (NREQ=4, WIDTH=2). Honours CMP_ARB_FIXED_PRIO_EN for the
//               arbitration-order expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic       rsp_eq;
  logic       rsp_lt;
  logic       rsp_gt;
  logic       busy;

  logic [5:0] rsp_bus;
  assign rsp_bus = {rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .rsp_gt    (rsp_gt),
    .busy      (busy)
  );

  function automatic logic [5:0] rsp_word(input logic v, input int id,
                                          input logic eq, input logic lt, input logic gt);
    return {v, 2'(id), eq, lt, gt};
  endfunction

  task automatic place(input int id, input logic [1:0] a, input logic [1:0] b);
    req_valid[id]          = 1'b1;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
  endtask

  // One complete transaction from a lone requester, consumer always ready.
  task automatic do_txn(input int id, input logic [1:0] a, input logic [1:0] b,
                        input logic eq, input logic lt, input logic gt, input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = '0;
    place(id, a, b);
    #1;
    n_checks++;
    if (req_ready !== 4'(1 << id)) begin
      n_errors++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, 4'(1 << id));
    end
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_valid, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
      n_errors++;
      $display("FAIL %s cmp_state: busy/rsp_valid/req_ready=%b expected 1_0_0000",
               tag, {busy, rsp_valid, req_ready});
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_bus !== rsp_word(1'b1, id, eq, lt, gt)) begin
      n_errors++;
      $display("FAIL %s resp: {valid,id,eq,lt,gt}=%b expected %b (a=%0d b=%0d)",
               tag, rsp_bus, rsp_word(1'b1, id, eq, lt, gt), a, b);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, rsp_bus} !== {1'b0, rsp_word(1'b0, id, eq, lt, gt)}) begin
      n_errors++;
      $display("FAIL %s after_resp: {busy,valid,id,eq,lt,gt}=%b expected %b",
               tag, {busy, rsp_bus}, {1'b0, rsp_word(1'b0, id, eq, lt, gt)});
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, busy, rsp_bus} !== 11'b0) begin
      n_errors++;
      $display("FAIL reset_hold: {req_ready,busy,rsp}=%b expected 0", {req_ready, busy, rsp_bus});
    end
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_idle: {req_ready,busy,rsp_valid}=%b expected 0", {req_ready, busy, rsp_valid});
    end
  endtask

  task automatic test_single();
    do_txn(1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, "single_gt");
  endtask

  task automatic test_equal_less();
    do_txn(0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, "equal");
    do_txn(2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "less");
  endtask

  task automatic test_all_pairs();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        do_txn((a * 4 + b) % NREQ, 2'(a), 2'(b), a == b, a < b, a > b, "pair");
      end
    end
  endtask

  // All four requesters held valid; slot i carries a=i, b=3-i.
  task automatic test_contention();
    int exp_id;
    reset_dut();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) place(i, 2'(i), 2'(3 - i));
    for (int k = 0; k < 5; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % NREQ;
`endif
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
        n_errors++;
        $display("FAIL contention_grant[%0d]: req_ready=%b expected %b", k, req_ready, 4'(1 << exp_id));
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (rsp_bus !== rsp_word(1'b1, exp_id, 1'b0, exp_id < 2, exp_id >= 2)) begin
        n_errors++;
        $display("FAIL contention_resp[%0d]: rsp=%b expected %b", k, rsp_bus,
                 rsp_word(1'b1, exp_id, 1'b0, exp_id < 2, exp_id >= 2));
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  // Requesters 0 and 2 held valid: alternate under round-robin, 0 always
  // under fixed priority.
  task automatic test_two_requesters();
    int exp_id;
    reset_dut();
    rsp_ready = 1'b1;
    place(0, 2'd1, 2'd0);
    place(2, 2'd0, 2'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = (k % 2) * 2;
`endif
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
        n_errors++;
        $display("FAIL two_req_grant[%0d]: req_ready=%b expected %b", k, req_ready, 4'(1 << exp_id));
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (rsp_bus !== rsp_word(1'b1, exp_id, 1'b0, exp_id == 2, exp_id == 0)) begin
        n_errors++;
        $display("FAIL two_req_resp[%0d]: rsp=%b expected %b", k, rsp_bus,
                 rsp_word(1'b1, exp_id, 1'b0, exp_id == 2, exp_id == 0));
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    place(3, 2'd1, 2'd3);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_errors++;
      $display("FAIL bp_grant: req_ready=%b expected 1000", req_ready);
    end
    @(negedge clk);
    // Changing operands after accept must not affect the result.
    place(3, 2'd3, 2'd1);
    place(0, 2'd0, 2'd0);
    place(1, 2'd0, 2'd0);
    place(2, 2'd0, 2'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({req_ready, busy, rsp_bus} !== {4'b0000, 1'b1, rsp_word(1'b1, 3, 1'b0, 1'b1, 1'b0)}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: {req_ready,busy,rsp}=%b expected %b", c,
                 {req_ready, busy, rsp_bus}, {4'b0000, 1'b1, rsp_word(1'b1, 3, 1'b0, 1'b1, 1'b0)});
      end
      if (c == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if ({busy, rsp_bus} !== {1'b0, rsp_word(1'b0, 3, 1'b0, 1'b1, 1'b0)}) begin
      n_errors++;
      $display("FAIL bp_release: {busy,rsp}=%b expected %b", {busy, rsp_bus},
               {1'b0, rsp_word(1'b0, 3, 1'b0, 1'b1, 1'b0)});
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_resp();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    place(2, 2'd3, 2'd0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_bus !== rsp_word(1'b1, 2, 1'b0, 1'b0, 1'b1)) begin
      n_errors++;
      $display("FAIL pre_reset_resp: rsp=%b expected %b", rsp_bus, rsp_word(1'b1, 2, 1'b0, 1'b0, 1'b1));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, busy, rsp_bus} !== 11'b0) begin
      n_errors++;
      $display("FAIL async_reset: {req_ready,busy,rsp}=%b expected 0", {req_ready, busy, rsp_bus});
    end
    @(negedge clk);
    rst_n = 1'b1;
    place(0, 2'd1, 2'd1);
    place(1, 2'd0, 2'd0);
    place(2, 2'd0, 2'd0);
    place(3, 2'd0, 2'd0);
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, busy, rsp_valid} !== {4'b0001, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL post_reset_grant: {req_ready,busy,rsp_valid}=%b expected 0001_0_0",
               {req_ready, busy, rsp_valid});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_bus !== rsp_word(1'b1, 0, 1'b1, 1'b0, 1'b0)) begin
      n_errors++;
      $display("FAIL post_reset_resp: rsp=%b expected %b", rsp_bus, rsp_word(1'b1, 0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_equal_less();
    test_all_pairs();
    test_contention();
    test_two_requesters();
    test_backpressure();
    test_reset_mid_resp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
